// File: rtl/mips_defs.sv
// Shared P7 MIPS definitions: opcode/funct encodings, fetch address map,
// exception codes and small enums used by the fetch-stage PC logic.
package mips_defs;

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_REGIMM  = 6'b000001;
  localparam logic [5:0] OP_J       = 6'b000010;
  localparam logic [5:0] OP_JAL     = 6'b000011;
  localparam logic [5:0] OP_BEQ     = 6'b000100;
  localparam logic [5:0] OP_BNE     = 6'b000101;
  localparam logic [5:0] OP_BLEZ    = 6'b000110;
  localparam logic [5:0] OP_BGTZ    = 6'b000111;

  localparam logic [5:0] FN_JR      = 6'b001000;
  localparam logic [5:0] FN_JALR    = 6'b001001;

  localparam logic [31:0] DEF_PC_RESET   = 32'h0000_3000;
  localparam logic [31:0] DEF_EXC_VECTOR = 32'h0000_4180;
  localparam logic [31:0] DEF_TEXT_LO    = 32'h0000_3000;
  localparam logic [31:0] DEF_TEXT_HI    = 32'h0000_6FFC;

  // ExcCode reported by the F-stage checker when ExcADEL is raised.
  localparam logic [4:0] EXC_ADEL = 5'd4;

  typedef enum logic {
    BD_NORMAL = 1'b0,
    BD_SLOT   = 1'b1
  } bd_state_t;

  typedef enum logic [2:0] {
    NPC_SEQ    = 3'd0,
    NPC_BRANCH = 3'd1,
    NPC_HOLD   = 3'd2,
    NPC_ERET   = 3'd3,
    NPC_EXC    = 3'd4
  } npc_sel_t;

endpackage

// File: rtl/branch_predecode.sv
// Combinational predecode: flags any branch or jump (including jr/jalr and
// the whole REGIMM group) so the following instruction can be marked as BD.
module branch_predecode
  import mips_defs::*;
(
  input  logic [31:0] instr,
  output logic        is_branch
);

  logic [5:0] opcode;
  logic [5:0] funct;
  logic       unused_fields;

  assign opcode        = instr[31:26];
  assign funct         = instr[5:0];
  assign unused_fields = ^instr[25:6];

  always_comb begin
    is_branch = 1'b0;
    case (opcode)
      OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ,
      OP_REGIMM, OP_J, OP_JAL: is_branch = 1'b1;
      OP_SPECIAL:              is_branch = (funct == FN_JR) || (funct == FN_JALR);
      default:                 is_branch = 1'b0;
    endcase
  end

endmodule

// File: rtl/f_pc_unit.sv
// Fetch-stage PC unit: next-PC selection, fetch address-error detection and
// the branch-delay-slot flag that travels with the fetched instruction.
module f_pc_unit
  import mips_defs::*;
#(
  parameter logic [31:0] PC_RESET   = DEF_PC_RESET,
  parameter logic [31:0] EXC_VECTOR = DEF_EXC_VECTOR,
  parameter logic [31:0] TEXT_LO    = DEF_TEXT_LO,
  parameter logic [31:0] TEXT_HI    = DEF_TEXT_HI
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Stall,
  input  logic        BranchTaken,
  input  logic [31:0] BranchTarget,
  input  logic        ExcEnter,
  input  logic        EretTaken,
  input  logic [31:0] EPC,
  input  logic [31:0] Instr,
  output logic [31:0] PC,
  output logic        ExcADEL,
  output logic        IsDelaySlot
);

  logic [31:0] pc_q;
  logic [31:0] pc_next;
  logic [31:0] pc_seq;
  npc_sel_t    npc_sel;
  logic        is_branch_raw;
  logic        is_branch_f;
  bd_state_t   bd_state;
  bd_state_t   bd_next;

  // Redirects from CP0 outrank the stall; a branch only lands when not stalled.
  always_comb begin
    npc_sel = NPC_SEQ;
    if (ExcEnter)         npc_sel = NPC_EXC;
    else if (EretTaken)   npc_sel = NPC_ERET;
    else if (Stall)       npc_sel = NPC_HOLD;
    else if (BranchTaken) npc_sel = NPC_BRANCH;
    else                  npc_sel = NPC_SEQ;
  end

  assign pc_seq = pc_q + 32'd4;

  always_comb begin
    pc_next = pc_seq;
    case (npc_sel)
      NPC_EXC:    pc_next = EXC_VECTOR;
      NPC_ERET:   pc_next = EPC;
      NPC_HOLD:   pc_next = pc_q;
      NPC_BRANCH: pc_next = BranchTarget;
      default:    pc_next = pc_seq;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) pc_q <= PC_RESET;
    else       pc_q <= pc_next;
  end

  assign PC      = pc_q;
  assign ExcADEL = (pc_q[1:0] != 2'b00) || (pc_q < TEXT_LO) || (pc_q > TEXT_HI);

  branch_predecode u_predecode (
    .instr     (Instr),
    .is_branch (is_branch_raw)
  );

  // A word fetched from a faulting address is treated as a NOP.
  assign is_branch_f = is_branch_raw && !ExcADEL;

  always_ff @(posedge clk) begin
    if (reset) bd_state <= BD_NORMAL;
    else       bd_state <= bd_next;
  end

  always_comb begin
    bd_next = bd_state;
    case (npc_sel)
      NPC_EXC, NPC_ERET: bd_next = BD_NORMAL;
      NPC_HOLD:          bd_next = bd_state;
      default:           bd_next = is_branch_f ? BD_SLOT : BD_NORMAL;
    endcase
  end

  always_comb begin
    IsDelaySlot = 1'b0;
    if (bd_state == BD_SLOT) IsDelaySlot = 1'b1;
  end

endmodule

// File: tb/tb_f_pc_unit.sv
// Self-checking bench for f_pc_unit: directed scenarios followed by random
// traffic, all checked against a behavioural model of the fetch PC.
module tb_f_pc_unit;

  localparam logic [31:0] PcReset   = 32'h0000_3000;
  localparam logic [31:0] ExcVector = 32'h0000_4180;
  localparam logic [31:0] TextLo    = 32'h0000_3000;
  localparam logic [31:0] TextHi    = 32'h0000_6FFC;
  localparam logic [31:0] Nop       = 32'h0000_0000;
  localparam logic [31:0] Beq       = 32'h1000_0003;

  logic        clk;
  logic        reset;
  logic        Stall;
  logic        BranchTaken;
  logic [31:0] BranchTarget;
  logic        ExcEnter;
  logic        EretTaken;
  logic [31:0] EPC;
  logic [31:0] Instr;
  logic [31:0] PC;
  logic        ExcADEL;
  logic        IsDelaySlot;

  int          testsRun = 0;
  int          testsFailed = 0;
  logic [31:0] modelPc = PcReset;
  logic        modelBd = 1'b0;

  f_pc_unit dut (
    .clk          (clk),
    .reset        (reset),
    .Stall        (Stall),
    .BranchTaken  (BranchTaken),
    .BranchTarget (BranchTarget),
    .ExcEnter     (ExcEnter),
    .EretTaken    (EretTaken),
    .EPC          (EPC),
    .Instr        (Instr),
    .PC           (PC),
    .ExcADEL      (ExcADEL),
    .IsDelaySlot  (IsDelaySlot)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  function automatic logic refAddrError(input logic [31:0] a);
    return (a % 4 != 0) || (a < TextLo) || (a > TextHi);
  endfunction

  function automatic logic refIsBranch(input logic [31:0] w);
    int op;
    int fn;
    op = int'(w >> 26);
    fn = int'(w % 64);
    return (op >= 1 && op <= 7) || (op == 0 && (fn == 8 || fn == 9));
  endfunction

  // One clock of stimulus; the model decides what the edge should produce.
  task automatic applyStimulus(input logic rst, input logic st, input logic bt,
                               input logic [31:0] tgt, input logic exc, input logic eret,
                               input logic [31:0] epc, input logic [31:0] instr,
                               input string tag);
    logic [31:0] expPc;
    logic        expBd;
    reset = rst; Stall = st; BranchTaken = bt; BranchTarget = tgt;
    ExcEnter = exc; EretTaken = eret; EPC = epc; Instr = instr;
    expPc = modelPc;
    expBd = modelBd;
    if (rst) begin
      expPc = PcReset;    expBd = 1'b0;
    end else if (exc) begin
      expPc = ExcVector;  expBd = 1'b0;
    end else if (eret) begin
      expPc = epc;        expBd = 1'b0;
    end else if (!st) begin
      expBd = !refAddrError(modelPc) && refIsBranch(instr);
      expPc = bt ? tgt : modelPc + 32'd4;
    end
    @(posedge clk);
    #1;
    modelPc = expPc;
    modelBd = expBd;
    checkOutput({tag, ".pc"}, PC, modelPc);
    checkOutput({tag, ".bd"}, 32'(IsDelaySlot), 32'(modelBd));
    checkOutput({tag, ".adel"}, 32'(ExcADEL), 32'(refAddrError(modelPc)));
  endtask

  function automatic logic [31:0] randInstr();
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(0, 3))
      0: w[31:26] = 6'($urandom_range(1, 7));
      1: begin w[31:26] = 6'd0; w[5:0] = ($urandom_range(0, 1) == 1) ? 6'd8 : 6'd9; end
      default: ;
    endcase
    return w;
  endfunction

  function automatic logic [31:0] randAddr();
    logic [31:0] a;
    case ($urandom_range(0, 5))
      0, 1, 2: a = TextLo + 32'($urandom_range(0, 32'hFFF) << 2);
      3:       a = TextLo + 32'($urandom_range(0, 32'h3FFF)) | 32'd1;
      4:       a = ($urandom_range(0, 1) == 1) ? TextHi + 32'd4 : TextLo - 32'd4;
      default: a = $urandom;
    endcase
    return a;
  endfunction

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1; Stall = 1'b0; BranchTaken = 1'b0; BranchTarget = '0;
    ExcEnter = 1'b0; EretTaken = 1'b0; EPC = '0; Instr = Nop;

    applyStimulus(1, 0, 0, 0, 0, 0, 0, Nop, "reset");
    checkOutput("reset.pcConst", PC, 32'h0000_3000);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, Nop, "free");
    checkOutput("free.pcConst", PC, 32'h0000_300C);

    applyStimulus(1, 0, 0, 0, 0, 0, 0, Nop, "reset2");
    applyStimulus(0, 0, 0, 0, 0, 0, 0, Nop, "toBeq");
    applyStimulus(0, 0, 0, 0, 0, 0, 0, Beq, "beqFetch");
    checkOutput("slot.bdConst", 32'(IsDelaySlot), 32'd1);
    applyStimulus(0, 0, 1, 32'h3020, 0, 0, 0, Nop, "branchTaken");
    checkOutput("target.pcConst", PC, 32'h0000_3020);

    applyStimulus(0, 1, 1, 32'h3040, 0, 0, 0, Beq, "stall1");
    applyStimulus(0, 1, 1, 32'h3040, 0, 0, 0, Beq, "stall2");
    checkOutput("stall.pcConst", PC, 32'h0000_3020);
    applyStimulus(0, 0, 1, 32'h3040, 0, 0, 0, Nop, "unstall");
    checkOutput("unstall.pcConst", PC, 32'h0000_3040);

    applyStimulus(0, 0, 1, 32'h3002, 0, 0, 0, Nop, "misalign");
    checkOutput("misalign.adelConst", 32'(ExcADEL), 32'd1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, Beq, "faultBeq");
    applyStimulus(0, 1, 0, 0, 1, 0, 0, Beq, "excStall");
    checkOutput("excStall.pcConst", PC, 32'h0000_4180);

    applyStimulus(0, 0, 1, 32'h3020, 0, 1, 32'h3010, Nop, "eretBranch");
    applyStimulus(0, 0, 0, 0, 1, 1, 32'h3010, Nop, "excEret");
    applyStimulus(0, 0, 1, 32'h7000, 0, 0, 0, Nop, "aboveText");
    applyStimulus(0, 0, 1, 32'h2FFC, 0, 0, 0, Nop, "belowText");
    applyStimulus(0, 0, 1, 32'h6FFC, 0, 0, 0, Beq, "topText");
    applyStimulus(0, 0, 1, 32'hFFFF_FFFC, 0, 0, 0, Nop, "wrapPre");
    applyStimulus(0, 0, 0, 0, 0, 0, 0, Nop, "wrap");
    checkOutput("wrap.pcConst", PC, 32'h0000_0000);
    applyStimulus(0, 0, 1, 32'h3000, 0, 0, 0, Beq, "preReset");
    applyStimulus(1, 1, 1, 32'h3040, 1, 1, 32'h3010, Beq, "midReset");

    for (int i = 0; i < 600; i++) begin
      applyStimulus($urandom_range(0, 49) == 0, $urandom_range(0, 3) == 0,
                    $urandom_range(0, 9) < 3, randAddr(),
                    $urandom_range(0, 19) == 0, $urandom_range(0, 19) == 0,
                    randAddr(), randInstr(), "rand");
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/f_pc_unit.md
# f_pc_unit

Fetch-stage program-counter unit of the P7 MIPS pipeline. It holds the fetch PC and selects the next PC: sequential, branch/jump target, exception vector, or EPC on `eret`. It flags fetch address errors (`ExcADEL`) that feed the F-stage exception checker. It also predecodes the fetched word to produce the branch-delay-slot (BD) flag that travels with the next instruction toward CP0.

## Interface
Parameters:
- `PC_RESET`, 32'h0000_3000, PC value after reset
- `EXC_VECTOR`, 32'h0000_4180, exception/interrupt handler entry
- `TEXT_LO`, 32'h0000_3000, lowest legal fetch address
- `TEXT_HI`, 32'h0000_6FFC, highest legal fetch address

Ports:
- `clk` in 1: single clock, rising edge
- `reset` in 1: synchronous, active-high
- `Stall` in 1: hazard stall, hold PC and BD
- `BranchTaken` in 1: D-stage branch/jump resolved taken
- `BranchTarget` in 32: D-stage target address
- `ExcEnter` in 1: CP0 has taken an exception or interrupt this cycle
- `EretTaken` in 1: `eret` commits this cycle
- `EPC` in 32: CP0 return address
- `Instr` in 32: instruction-memory word at `PC`
- `PC` out 32: current fetch address (registered)
- `ExcADEL` out 1: fetch address error at `PC` (combinational from `PC`)
- `IsDelaySlot` out 1: the instruction at `PC` is in a branch delay slot (registered)

## Operation
- Next-PC priority, highest first:
  - `ExcEnter` loads `EXC_VECTOR`.
  - `EretTaken` loads `EPC`.
  - `Stall` holds `PC`.
  - `BranchTaken` loads `BranchTarget`.
  - Otherwise `PC + 4`.
- A redirect (`ExcEnter` or `EretTaken`) overrides `Stall`.
- `BranchTaken` during `Stall` is ignored. The D stage re-asserts it when the stall clears.
- `ExcADEL = (PC[1:0] != 0) | (PC < TEXT_LO) | (PC > TEXT_HI)`. All comparisons are unsigned 32-bit.
- `PC + 4` wraps modulo 2^32. The wrapped value is flagged by `ExcADEL` and is not otherwise special.
- Predecode `IsBranchF` from `Instr`. It is true for:
  - opcode 000100–000111 (`beq`, `bne`, `blez`, `bgtz`)
  - opcode 000001 (`bltz`/`bgez` and the rest of the REGIMM group)
  - opcode 000010 (`j`), 000011 (`jal`)
  - opcode 000000 with funct 001000 (`jr`) or 001001 (`jalr`)
- While `ExcADEL` is 1, `IsBranchF` is forced to 0 (the word is treated as a NOP).
- BD register update:
  - On a redirect: `IsDelaySlot <= 0`.
  - On stall: hold.
  - On any other advance (sequential or branch): `IsDelaySlot <= IsBranchF`.
- Two states via the BD register: NORMAL (`IsDelaySlot=0`) and SLOT (`IsDelaySlot=1`). SLOT lasts until the next advance or redirect.
- Reset:
  - `PC = PC_RESET`, `IsDelaySlot = 0`.
  - `ExcADEL` then evaluates to 0 (for the default parameters).
  - Reset mid-operation discards any pending branch or redirect.

## Timing
- All state updates occur on the rising edge of `clk`. Next-PC inputs sampled at edge N are visible on `PC` after edge N.
- Redirect latency is 1 cycle: `ExcEnter` high in cycle N gives `PC = EXC_VECTOR` in cycle N+1.
- `ExcADEL` and `IsBranchF` are combinational from `PC`/`Instr` in the same cycle. `ExcADEL` must not depend on any input other than `PC`.
- Simultaneous events:
  - `ExcEnter` with `EretTaken`: `ExcEnter` wins.
  - `ExcEnter` with `Stall`: the vector is still loaded.
  - `reset` with anything: `reset` wins.
- No handshake: `Stall` is level-sensitive and applies in the cycle it is asserted.

## Structure
- Shared package `mips_defs`:
  - opcode/funct constants (`OP_BEQ`, `OP_REGIMM`, `OP_J`, `OP_JAL`, `FN_JR`, `FN_JALR`)
  - `EXC_VECTOR` default and text-segment bounds
  - `EXC_ADEL = 5'd4`, consumed downstream by the F-stage checker
- One natural sub-module, `branch_predecode`: combinational `Instr` → `IsBranchF`. It is reusable in the D stage.
- The next-PC mux, PC register, range check and BD register stay in the top module.

## Test plan
- Reset, then 3 free-running cycles → `PC` = 0x3000, 0x3004, 0x3008, 0x300C; `IsDelaySlot` = 0; `ExcADEL` = 0.
- `Instr` = `beq` (0x10000003) at `PC`=0x3004, advance; then `BranchTaken`=1 with target 0x3020 → `PC`=0x3008 with `IsDelaySlot`=1, then `PC`=0x3020 with `IsDelaySlot`=0 (assuming the slot word is not a branch).
- `Stall`=1 for 2 cycles while `BranchTaken`=1 and target 0x3040 → `PC` and `IsDelaySlot` unchanged. When `Stall` drops with `BranchTaken` still 1 → `PC`=0x3040.
- `BranchTarget`=0x3002 taken → `PC`=0x3002, `ExcADEL`=1, and `Instr` is ignored for BD. Then `ExcEnter`=1 together with `Stall`=1 → `PC`=0x4180, `IsDelaySlot`=0, `ExcADEL`=0.
- `EretTaken`=1 with `EPC`=0x3010 in the same cycle as `BranchTaken` → `PC`=0x3010. Then `ExcEnter` and `EretTaken` together → `PC`=0x4180.
- `BranchTarget`=0x7000 taken → `ExcADEL`=1. `BranchTarget`=0x2FFC taken → `ExcADEL`=1. Assert `reset` in the following cycle → `PC`=0x3000, `IsDelaySlot`=0.
